// File: rtl/rtc_pkg.sv
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared constants for the RTC bus scheduler: FSM state
//                encoding, bus-cycle kinds, RTC register address map,
//                RTC command bytes and register index constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

    // Scheduler FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD_RD = 3'd1;
    localparam logic [2:0] c_ST_READ   = 3'd2;
    localparam logic [2:0] c_ST_WRITE  = 3'd3;
    localparam logic [2:0] c_ST_CMD_WR = 3'd4;
    localparam logic [2:0] c_ST_INIT   = 3'd5;

    // Bus cycle kinds: command = address phase only
    localparam logic [1:0] c_K_CMD = 2'd0;
    localparam logic [1:0] c_K_WR  = 2'd1;
    localparam logic [1:0] c_K_RD  = 2'd2;

    // RTC command bytes
    localparam logic [7:0] c_CMD_RAM_COPY = 8'hF0;  // RTC registers -> RAM copy before read-back
    localparam logic [7:0] c_CMD_SET_TD   = 8'hF1;  // commit time/date edits
    localparam logic [7:0] c_CMD_SET_TMR  = 8'hF2;  // commit timer edits

    // Oscillator/control initialisation
    localparam logic [7:0] c_INIT_ADDR  = 8'h02;
    localparam logic [7:0] c_INIT_DATA0 = 8'h10;
    localparam logic [7:0] c_INIT_DATA1 = 8'h00;

    // Register indices
    localparam logic [3:0] c_IDX_SS    = 4'd0;
    localparam logic [3:0] c_IDX_MM    = 4'd1;
    localparam logic [3:0] c_IDX_HH    = 4'd2;
    localparam logic [3:0] c_IDX_DAY   = 4'd3;
    localparam logic [3:0] c_IDX_MES   = 4'd4;
    localparam logic [3:0] c_IDX_YEAR  = 4'd5;
    localparam logic [3:0] c_IDX_SS_T  = 4'd6;
    localparam logic [3:0] c_IDX_MM_T  = 4'd7;
    localparam logic [3:0] c_IDX_HH_T  = 4'd8;
    localparam logic [3:0] c_IDX_LAST  = c_IDX_HH_T;

    // RTC bus address of a register index
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h41;
            4'd7:    reg_addr = 8'h42;
            4'd8:    reg_addr = 8'h43;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    // First register index of a write-back group (1=time, 2=date, 3=timer)
    function automatic logic [3:0] grp_base(input logic [1:0] grp);
        case (grp)
            2'd1:    grp_base = c_IDX_SS;
            2'd2:    grp_base = c_IDX_DAY;
            2'd3:    grp_base = c_IDX_SS_T;
            default: grp_base = c_IDX_SS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_bus_cycle.sv
// ============================================================================
//  Module      : rtc_bus_cycle
//  Description : Generates one RTC bus access (address + data phase) or one
//                command (address phase only). Each phase holds cs_n and the
//                strobe low for T_STROBE cycles, then T_GAP idle cycles.
//                All pins are registered. o_done marks the final cycle so a
//                new start may be issued in that cycle without a bus gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_STROBE = 4,
    parameter int T_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_kind,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    input  logic [7:0] i_ad_in,
    output logic       o_active,
    output logic       o_done,
    output logic       o_cs_n,
    output logic       o_rd_n,
    output logic       o_wr_n,
    output logic       o_a_d,
    output logic [7:0] o_ad_out,
    output logic       o_ad_oe,
    output logic [7:0] o_rdata,
    output logic       o_rvalid
);

    localparam int             c_PHASE = T_STROBE + T_GAP;
    localparam int             c_CW    = $clog2(c_PHASE + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_PHASE - 1);
    localparam logic [c_CW-1:0] c_TS   = c_CW'(T_STROBE);
    localparam logic [c_CW-1:0] c_TSM1 = c_CW'(T_STROBE - 1);

    logic            r_active, r_phase;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_kind;
    logic [7:0]      r_addr, r_data;
    logic            r_cs_n, r_rd_n, r_wr_n, r_a_d, r_ad_oe, r_rvalid;
    logic [7:0]      r_ad_out, r_rdata;

    logic            w_active_n, w_phase_n;
    logic [c_CW-1:0] w_cnt_n;
    logic [1:0]      w_kind_n;
    logic [7:0]      w_addr_n, w_data_n;
    logic            w_last, w_done, w_strobe_n, w_rd_ph_n, w_sample;

    assign w_last   = r_active && (r_cnt == c_LAST);
    assign w_done   = w_last && (r_phase || (r_kind == c_K_CMD));
    // Last rd_n-low cycle of a read data phase
    assign w_sample = r_active && r_phase && (r_kind == c_K_RD) && (r_cnt == c_TSM1);

    // Next phase/counter state; write data is captured on entering the data phase
    always_comb begin
        w_active_n = r_active;
        w_phase_n  = r_phase;
        w_cnt_n    = r_cnt;
        w_kind_n   = r_kind;
        w_addr_n   = r_addr;
        w_data_n   = r_data;
        if (i_start) begin
            w_active_n = 1'b1;
            w_phase_n  = 1'b0;
            w_cnt_n    = '0;
            w_kind_n   = i_kind;
            w_addr_n   = i_addr;
        end else if (r_active) begin
            if (w_last) begin
                if (!w_done) begin
                    w_phase_n = 1'b1;
                    w_cnt_n   = '0;
                    w_data_n  = i_data;
                end else begin
                    w_active_n = 1'b0;
                    w_phase_n  = 1'b0;
                    w_cnt_n    = '0;
                end
            end else begin
                w_cnt_n = r_cnt + 1'b1;
            end
        end
    end

    assign w_strobe_n = w_active_n && (w_cnt_n < c_TS);
    assign w_rd_ph_n  = w_phase_n && (w_kind_n == c_K_RD);

    // Counter state, registered pins and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
            r_kind   <= c_K_CMD;
            r_addr   <= 8'h00;
            r_data   <= 8'h00;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b0;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
        end else begin
            r_active <= w_active_n;
            r_phase  <= w_phase_n;
            r_cnt    <= w_cnt_n;
            r_kind   <= w_kind_n;
            r_addr   <= w_addr_n;
            r_data   <= w_data_n;
            r_cs_n   <= !w_strobe_n;
            r_rd_n   <= !(w_strobe_n && w_rd_ph_n);
            r_wr_n   <= !(w_strobe_n && !w_rd_ph_n);
            r_a_d    <= w_active_n && w_phase_n;
            r_ad_oe  <= w_active_n && !w_rd_ph_n;
            if (!w_active_n || w_rd_ph_n) begin
                r_ad_out <= 8'h00;
            end else begin
                r_ad_out <= w_phase_n ? w_data_n : w_addr_n;
            end
            r_rvalid <= w_sample;
            if (w_sample) begin
                r_rdata <= i_ad_in;
            end
        end
    end

    assign o_active = r_active;
    assign o_done   = w_done;
    assign o_cs_n   = r_cs_n;
    assign o_rd_n   = r_rd_n;
    assign o_wr_n   = r_wr_n;
    assign o_a_d    = r_a_d;
    assign o_ad_out = r_ad_out;
    assign o_ad_oe  = r_ad_oe;
    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: rtl/rtc_bus_scheduler.sv
// ============================================================================
//  Module      : rtc_bus_scheduler
//  Description : Owns the RTC multiplexed bus. Schedules config write-back
//                bursts (3 registers of one group + commit command) and
//                periodic read-back bursts (RAM-copy command + 9 reads).
//                Write-back wins over read-back; bursts are never preempted.
//                Optional build macro RTC_INIT_SEQ_EN adds a post-reset INIT
//                state writing 10 then 00 to RTC address 02.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter int T_STROBE = 4,
    parameter int T_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rd_tick,
    input  logic       i_wr_req,
    input  logic [1:0] i_wr_group,
    output logic [3:0] o_wr_idx,
    input  logic [7:0] i_wr_data,
    output logic [3:0] o_rd_idx,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy,
    output logic       o_cs_n,
    output logic       o_rd_n,
    output logic       o_wr_n,
    output logic       o_a_d,
    output logic [7:0] o_ad_out,
    output logic       o_ad_oe,
    input  logic [7:0] i_ad_in
);

`ifdef RTC_INIT_SEQ_EN
    localparam logic [2:0] c_ST_RESET = c_ST_INIT;
`else
    localparam logic [2:0] c_ST_RESET = c_ST_IDLE;
`endif

    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_idx, r_wr_idx, r_rd_idx;
    logic       r_rd_pend, r_wr_pend, r_busy;
    logic [1:0] r_wr_grp, r_burst_grp;

    logic       w_done, w_bc_active;
    logic       w_start;
    logic [1:0] w_kind;
    logic [7:0] w_addr, w_data;
    logic [3:0] w_nidx, w_wr_last;
    logic       w_launch_wr, w_launch_rd, w_rd_last, w_wr_end;

    assign w_launch_wr = (r_state == c_ST_IDLE) && r_wr_pend;
    assign w_launch_rd = (r_state == c_ST_IDLE) && !r_wr_pend && r_rd_pend;
    assign w_wr_last   = grp_base(r_burst_grp) + 4'd2;
    assign w_rd_last   = (r_idx == c_IDX_LAST);
    assign w_wr_end    = (r_idx == w_wr_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every burst state advances on the bus-cycle done pulse
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_wr_pend) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (r_rd_pend) begin
                    w_state_nxt = c_ST_CMD_RD;
                end
            end
            c_ST_CMD_RD: if (w_done) w_state_nxt = c_ST_READ;
            c_ST_READ:   if (w_done && w_rd_last) w_state_nxt = c_ST_IDLE;
            c_ST_WRITE:  if (w_done && w_wr_end) w_state_nxt = c_ST_CMD_WR;
            c_ST_CMD_WR: if (w_done) w_state_nxt = c_ST_IDLE;
            c_ST_INIT:   if (w_done && (r_idx == 4'd1)) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic: launch the next bus cycle in the done cycle of the previous one
    always_comb begin
        w_start = 1'b0;
        w_kind  = c_K_CMD;
        w_addr  = 8'h00;
        w_data  = i_wr_data;
        w_nidx  = r_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (r_wr_pend) begin
                    w_start = 1'b1;
                    w_kind  = c_K_WR;
                    w_nidx  = grp_base(r_wr_grp);
                    w_addr  = reg_addr(grp_base(r_wr_grp));
                end else if (r_rd_pend) begin
                    w_start = 1'b1;
                    w_addr  = c_CMD_RAM_COPY;
                end
            end
            c_ST_CMD_RD: begin
                if (w_done) begin
                    w_start = 1'b1;
                    w_kind  = c_K_RD;
                    w_nidx  = c_IDX_SS;
                    w_addr  = reg_addr(c_IDX_SS);
                end
            end
            c_ST_READ: begin
                if (w_done && !w_rd_last) begin
                    w_start = 1'b1;
                    w_kind  = c_K_RD;
                    w_nidx  = r_idx + 4'd1;
                    w_addr  = reg_addr(r_idx + 4'd1);
                end
            end
            c_ST_WRITE: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (w_wr_end) begin
                        w_addr = (r_burst_grp == 2'd3) ? c_CMD_SET_TMR : c_CMD_SET_TD;
                    end else begin
                        w_kind = c_K_WR;
                        w_nidx = r_idx + 4'd1;
                        w_addr = reg_addr(r_idx + 4'd1);
                    end
                end
            end
            c_ST_INIT: begin
                w_kind = c_K_WR;
                w_addr = c_INIT_ADDR;
                w_data = (r_idx == 4'd0) ? c_INIT_DATA0 : c_INIT_DATA1;
                if (!w_bc_active) begin
                    w_start = 1'b1;
                end else if (w_done && (r_idx == 4'd0)) begin
                    w_start = 1'b1;
                    w_nidx  = 4'd1;
                end
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Index counter, index outputs, busy, and pending flags.
    // A pending flag is cleared when its burst launches, so a request
    // arriving during its own burst re-pends it for a later burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 4'd0;
            r_wr_idx    <= 4'd0;
            r_rd_idx    <= 4'd0;
            r_busy      <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_grp    <= 2'd0;
            r_burst_grp <= 2'd0;
        end else begin
            r_busy <= (w_state_nxt != c_ST_IDLE);
            if (w_start) begin
                r_idx <= w_nidx;
                if ((w_kind == c_K_WR) && (r_state != c_ST_INIT)) begin
                    r_wr_idx <= w_nidx;
                end
                if (w_kind == c_K_RD) begin
                    r_rd_idx <= w_nidx;
                end
            end
            if (w_launch_wr) begin
                r_burst_grp <= r_wr_grp;
            end
            if (i_rd_tick) begin
                r_rd_pend <= 1'b1;
            end else if (w_launch_rd) begin
                r_rd_pend <= 1'b0;
            end
            if (i_wr_req && (i_wr_group != 2'd0)) begin
                r_wr_pend <= 1'b1;
                r_wr_grp  <= i_wr_group;
            end else if (w_launch_wr) begin
                r_wr_pend <= 1'b0;
            end
        end
    end

    rtc_bus_cycle #(
        .T_STROBE (T_STROBE),
        .T_GAP    (T_GAP)
    ) u_bus_cycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_kind   (w_kind),
        .i_addr   (w_addr),
        .i_data   (w_data),
        .i_ad_in  (i_ad_in),
        .o_active (w_bc_active),
        .o_done   (w_done),
        .o_cs_n   (o_cs_n),
        .o_rd_n   (o_rd_n),
        .o_wr_n   (o_wr_n),
        .o_a_d    (o_a_d),
        .o_ad_out (o_ad_out),
        .o_ad_oe  (o_ad_oe),
        .o_rdata  (o_rd_data),
        .o_rvalid (o_rd_valid)
    );

    assign o_busy   = r_busy;
    assign o_wr_idx = r_wr_idx;
    assign o_rd_idx = r_rd_idx;

endmodule

`default_nettype wire
